// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   keypad_state_e : scanner FSM state encoding
//   NUM_ROWS       : number of keypad rows (and columns)
//   KEY_MAP        : hex code for each (row_idx, column) position
//   row_onehot()   : row index to one-hot row drive pattern
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } keypad_state_e;

  // Indexed as KEY_MAP[row_idx][column], column 0 is col[0].
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_ROWS] = '{
    '{4'hA, 4'h0, 4'hB, 4'hF},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h1, 4'h2, 4'h3, 4'hC}
  };

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: key event stream from the scanner to its consumer.
//   key_valid : scanner has a debounced key code available
//   key_code  : hex code of the accepted key
//   key_ready : consumer accepts key_code this cycle
//   key_held  : a key is being debounced, emitted or awaiting release
// Handshake: key_valid/key_code are held stable until a cycle in which
// key_valid and key_ready are both high; that cycle transfers the key, and
// key_valid drops on the following cycle. key_ready may be driven freely.
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_held;

  modport master (
    output key_valid,
    output key_code,
    output key_held,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_held,
    output key_ready
  );
endinterface

// File: rtl/keypad_decode.sv
// keypad_decode: combinational key lookup.
//   row_idx    : currently driven row (0..3)
//   col        : column sense pattern
//   code       : KEY_MAP entry for row_idx and the set column (only
//                meaningful when single_hot is high)
//   single_hot : exactly one column bit is set
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [3:0] col,
  output logic [3:0] code,
  output logic       single_hot
);

  logic [1:0] col_idx;

  always_comb begin
    col_idx = 2'd0;
    case (col)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign code       = KEY_MAP[row_idx][col_idx];
  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign single_hot = (col != 4'd0) && ((col & (col - 4'd1)) == 4'd0);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and a
// valid/ready key event output.
//   clk       : clock
//   reset     : synchronous active-high reset
//   col       : column sense (active high, already synchronized)
//   row       : one-hot row drive
//   key_if    : key event stream (master side), see keypad_scan_ctrl_if
//   state_dbg : current FSM state (keypad_state_e encoding)
// Each row is driven for SETTLE_CYCLES before its columns are sampled. A
// single-column hit is debounced for DEBOUNCE_CYCLES, emitted once, and the
// scanner then waits for DEBOUNCE_CYCLES of all-zero columns before moving
// on. Multi-column samples are treated as ghosting and skipped.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          col,
  output logic [3:0]          row,
  keypad_scan_ctrl_if.master  key_if,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] SCAN     = ST_SCAN;
  localparam logic [1:0] DEBOUNCE = ST_DEBOUNCE;
  localparam logic [1:0] EMIT     = ST_EMIT;
  localparam logic [1:0] RELEASE  = ST_RELEASE;

  // One counter is shared by settle, debounce and release timing; it only
  // ever needs to reach the larger terminal value minus one.
  localparam int MAX_CNT = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                             : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       state_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       col_lat_q;
  logic             key_valid_q;
  logic [3:0]       key_code_q;

  logic [3:0]       dec_col;
  logic [3:0]       dec_code;
  logic             dec_single_hot;
  logic [1:0]       row_idx_inc;

  // In SCAN the live columns are qualified; afterwards the latched pattern
  // supplies the code so it matches what was debounced.
  assign dec_col     = (state_q == SCAN) ? col : col_lat_q;
  assign row_idx_inc = row_idx_q + 2'd1;

  keypad_decode u_decode (
    .row_idx    (row_idx_q),
    .col        (dec_col),
    .code       (dec_code),
    .single_hot (dec_single_hot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b0001;
      cnt_q       <= '0;
      col_lat_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q <= '0;
            if (dec_single_hot) begin
              col_lat_q <= col;
              state_q   <= DEBOUNCE;
            end else begin
              // Nothing pressed, or a ghost/multi-key pattern: next row.
              row_idx_q <= row_idx_inc;
              row_q     <= row_onehot(row_idx_inc);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (col != col_lat_q) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end else if (cnt_q == DEBOUNCE_LAST) begin
            state_q     <= EMIT;
            cnt_q       <= '0;
            key_valid_q <= 1'b1;
            key_code_q  <= dec_code;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        EMIT: begin
          // key_valid_q is always high here; columns are ignored.
          if (key_if.key_ready) begin
            key_valid_q <= 1'b0;
            state_q     <= RELEASE;
            cnt_q       <= '0;
          end
        end

        RELEASE: begin
          if (col != 4'd0) begin
            cnt_q <= '0;
          end else if (cnt_q == DEBOUNCE_LAST) begin
            state_q   <= SCAN;
            cnt_q     <= '0;
            row_idx_q <= row_idx_inc;
            row_q     <= row_onehot(row_idx_inc);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= SCAN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign row              = row_q;
  assign state_dbg        = state_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_code  = key_code_q;
  assign key_if.key_held  = (state_q != SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [1:0] state_dbg;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_if    (kif),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keypad model ----------------
  // With model_en the model closes one switch (key_row, key_col): the column
  // reads high only while that row is driven. Otherwise direct_col is used.
  logic       model_en;
  logic       key_down;
  logic [1:0] key_row;
  logic [3:0] key_col;
  logic [3:0] direct_col;
  logic [3:0] key_row_oh;

  assign key_row_oh = 4'b0001 << key_row;
  assign col = model_en ? ((key_down && row == key_row_oh) ? key_col : 4'd0)
                        : direct_col;

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Handshake monitor, sampling mid-cycle after the negedge drivers settle.
  always begin
    logic [3:0] e;
    @(negedge clk);
    #2;
    if (!reset && kif.key_valid && kif.key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", kif.key_code);
      end else begin
        e = exp_q.pop_front();
        if (kif.key_code !== e) begin
          failures++;
          $display("FAIL key_code actual=%0h required=%0h", kif.key_code, e);
        end
      end
      hs_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_held(input logic level, input string name);
    int n = 0;
    while (kif.key_held !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (kif.key_held !== level) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (kif.key_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (kif.key_valid !== 1'b1) timeout_fail(name);
  endtask

  task automatic wait_hs(input int start, input string name);
    int n = 0;
    while (hs_count == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (hs_count == start) timeout_fail(name);
  endtask

  // Lands on the first cycle a row is driven (settle counter at 0).
  task automatic wait_row_start(input logic [3:0] target, input string name);
    int n = 0;
    while (row == target && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (row != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (row != target) timeout_fail(name);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0] r;
    logic [3:0] c;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] idle_rows[10];

  initial begin
    int start;
    int t;
    logic [1:0] nr;

    vecs[0] = '{2'd0, 4'b0001, 4'hA};
    vecs[1] = '{2'd0, 4'b0100, 4'hB};
    vecs[2] = '{2'd1, 4'b0010, 4'h8};
    vecs[3] = '{2'd1, 4'b1000, 4'hE};
    vecs[4] = '{2'd2, 4'b0010, 4'h5};
    vecs[5] = '{2'd2, 4'b0001, 4'h4};
    vecs[6] = '{2'd3, 4'b0100, 4'h3};
    vecs[7] = '{2'd3, 4'b1000, 4'hC};
    vecs[8] = '{2'd0, 4'b0010, 4'h0};
    vecs[9] = '{2'd3, 4'b0001, 4'h1};
    idle_rows = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

    reset = 1'b1; kif.key_ready = 1'b1;
    model_en = 1'b1; key_down = 1'b0; key_row = 2'd0; key_col = 4'd0;
    direct_col = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_row", row, 4'b0001);
    check("rst_valid", kif.key_valid, 0);
    check("rst_held", kif.key_held, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;

    // Idle scan: each row held for two cycles, no events
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("idle_row_%0d", i), row, idle_rows[i]);
      check($sformatf("idle_valid_%0d", i), kif.key_valid, 0);
    end

    // Fixed latency: key '5' on row 2; key_held rises the cycle after the
    // sample, key_valid four cycles after that, for a single cycle.
    key_row = 2'd2; key_col = 4'b0010; exp_q.push_back(4'h5); key_down = 1'b1;
    wait_held(1'b1, "lat_held_rise");
    check("lat_sample_row", row, 4'b0100);
    t = 0;
    while (kif.key_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_cycles", t, 4);
    @(negedge clk);
    check("lat_pulse_end", kif.key_valid, 0);
    key_down = 1'b0;
    wait_held(1'b0, "lat_release");

    // Table: every key position class, random consumer delay
    for (int i = 0; i < 10; i++) begin
      kif.key_ready = 1'b0;
      key_row = vecs[i].r; key_col = vecs[i].c;
      exp_q.push_back(vecs[i].code);
      start = hs_count;
      key_down = 1'b1;
      wait_valid($sformatf("vec_%0d_valid", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kif.key_ready = 1'b1;
      wait_hs(start, $sformatf("vec_%0d_hs", i));
      key_down = 1'b0;
      wait_held(1'b0, $sformatf("vec_%0d_release", i));
      nr = vecs[i].r + 2'd1;
      check($sformatf("vec_%0d_next_row", i), row, 4'b0001 << nr);
    end

    // Bounce: two matching debounce cycles, then open -> no event
    model_en = 1'b0;
    start = hs_count;
    wait_row_start(4'b0100, "bounce_row");
    direct_col = 4'b0010;
    repeat (2) @(negedge clk);
    check("bounce_in_debounce", kif.key_held, 1);
    repeat (2) @(negedge clk);
    direct_col = 4'd0;
    @(negedge clk);
    check("bounce_row_kept", row, 4'b0100);
    check("bounce_held_low", kif.key_held, 0);
    repeat (2) @(negedge clk);
    check("bounce_scan_resume", row, 4'b1000);
    repeat (10) @(negedge clk);
    check("bounce_no_event", hs_count - start, 0);

    // Ghost / multi-key sample on row 0 -> rejected, row advances
    wait_row_start(4'b0001, "ghost_row");
    direct_col = 4'b0011;
    repeat (2) @(negedge clk);
    check("ghost_row_adv", row, 4'b0010);
    check("ghost_held", kif.key_held, 0);
    direct_col = 4'd0;
    repeat (10) @(negedge clk);
    check("ghost_no_event", hs_count - start, 0);
    model_en = 1'b1;

    // Backpressure with release and re-press during EMIT
    kif.key_ready = 1'b0;
    key_row = 2'd1; key_col = 4'b0100; exp_q.push_back(4'h9);
    start = hs_count;
    key_down = 1'b1;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), kif.key_valid, 1);
      check($sformatf("bp_code_%0d", i), kif.key_code, 4'h9);
      if (i == 3) key_down = 1'b0;
      if (i == 6) key_down = 1'b1;
      @(negedge clk);
    end
    kif.key_ready = 1'b1;
    wait_hs(start, "bp_hs");
    check("bp_valid_drop", kif.key_valid, 0);
    repeat (6) @(negedge clk);
    key_down = 1'b0;
    wait_held(1'b0, "bp_release");
    repeat (30) @(negedge clk);
    check("bp_single_event", hs_count - start, 1);

    // Reset during EMIT discards the pending key
    kif.key_ready = 1'b0;
    key_row = 2'd3; key_col = 4'b0001;
    start = hs_count;
    key_down = 1'b1;
    wait_valid("rst_emit_valid");
    reset = 1'b1;
    @(negedge clk);
    check("rst_emit_valid_low", kif.key_valid, 0);
    check("rst_emit_row", row, 4'b0001);
    check("rst_emit_held", kif.key_held, 0);
    check("rst_emit_state", state_dbg, 0);
    key_down = 1'b0;
    reset = 1'b0;
    kif.key_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_emit_no_reemit", hs_count - start, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
